// File: rtl/fifo_pkt_mover.sv
// fifo_pkt_mover: pops header+payload packets from a show-ahead FIFO and writes the payload over Avalon-MM.
// Optional FIFO_PKT_MOVER_PKT_COUNT_EN adds a 16-bit completed-packet counter output.
module fifo_pkt_mover #(
  parameter int PACKET_SIZE = 4,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   fifo_rdata,
  input  logic                fifo_empty,
  output logic                fifo_rdreq,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  output logic                irq,
  input  logic                irq_clear,
`ifdef FIFO_PKT_MOVER_PKT_COUNT_EN
  output logic [15:0]         pkt_count,
`endif
  output logic                busy
);
  localparam int CW = (PACKET_SIZE > 2) ? $clog2(PACKET_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PACKET_SIZE - 2);
  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;
  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_addr, w_addr, r_avm_addr, w_avm_addr;
  logic [CW-1:0]       r_cnt, w_cnt;
  logic [DATA_W-1:0]   r_wdata, w_wdata;
  logic [DATA_W/8-1:0] r_be;
  logic                r_write, w_write, r_irq, w_irq, r_busy;
  logic                w_pop, w_load, w_acc;
  // the pop strobe is decoded from the registered state so the pop lands in the cycle the head word is consumed
  assign w_pop  = ~reset & ~fifo_empty & (r_state == IDLE || r_state == FETCH);
  assign w_load = r_state == FETCH && !fifo_empty;
  assign w_acc  = r_state == WRITE && !avm_waitrequest;
  assign fifo_rdreq     = w_pop;
  assign avm_address    = r_avm_addr;
  assign avm_write      = r_write;
  assign avm_writedata  = r_wdata;
  assign avm_byteenable = r_be;
  assign irq            = r_irq;
  assign busy           = r_busy;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_avm_addr <= '0;
      r_wdata    <= '0;
      r_write    <= 1'b0;
      r_be       <= '0;
      r_irq      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_addr     <= w_addr;
      r_cnt      <= w_cnt;
      r_avm_addr <= w_avm_addr;
      r_wdata    <= w_wdata;
      r_write    <= w_write;
      r_be       <= {(DATA_W/8){w_write}};
      r_irq      <= w_irq;
      r_busy     <= w_next != IDLE;
    end
  always_comb begin
    w_next = (r_state == IDLE)  ? (fifo_empty ? IDLE : FETCH) :
             (r_state == FETCH) ? (fifo_empty ? FETCH : WRITE) :
             (r_state == WRITE) ? (avm_waitrequest ? WRITE : (r_cnt == LAST ? DONE : FETCH)) :
             IDLE;
  end
  always_comb begin
    w_addr     = (r_state == IDLE && !fifo_empty) ? {fifo_rdata[ADDR_W-1:2], 2'b00} :
                 w_acc ? r_addr + ADDR_W'(4) : r_addr;
    w_cnt      = (r_state == IDLE) ? '0 : w_acc ? r_cnt + CW'(1) : r_cnt;
    w_write    = w_load | (r_write & ~w_acc);
    w_avm_addr = w_load ? r_addr : r_avm_addr;
    w_wdata    = w_load ? fifo_rdata : r_wdata;
    w_irq      = (r_state == DONE) | (r_irq & ~irq_clear);
  end
`ifdef FIFO_PKT_MOVER_PKT_COUNT_EN
  logic [15:0] r_pkt_count;
  assign pkt_count = r_pkt_count;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_pkt_count <= '0;
    else if (r_state == DONE) r_pkt_count <= r_pkt_count + 16'd1;
`endif
endmodule

// File: tb/tb_fifo_pkt_mover.sv
// tb_fifo_pkt_mover: randomized and directed bench against a packet-level write/irq reference model.
module tb_fifo_pkt_mover;
  localparam int PS = 4;
  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] fifo_rdata = '0;
  logic        fifo_empty = 1'b1, fifo_rdreq;
  logic [31:0] avm_address, avm_writedata;
  logic        avm_write, avm_waitrequest = 1'b0;
  logic [3:0]  avm_byteenable;
  logic        irq, irq_clear = 1'b0, busy;
`ifdef FIFO_PKT_MOVER_PKT_COUNT_EN
  logic [15:0] pkt_count;
`endif
  fifo_pkt_mover #(.PACKET_SIZE(PS), .DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
    .fifo_rdreq(fifo_rdreq), .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .irq(irq), .irq_clear(irq_clear),
`ifdef FIFO_PKT_MOVER_PKT_COUNT_EN
    .pkt_count(pkt_count),
`endif
    .busy(busy));
  always #5 clk = ~clk;
  typedef struct {logic [31:0] addr; logic [31:0] data; bit last;} wr_t;
  logic [31:0] fifo_q[$];
  wr_t         exp_q[$];
  int          n_tests = 0, n_fail = 0, smp = 0, first_wr_smp = -1, n_pop = 0, n_acc = 0;
  bit          m_irq = 0, done_pending = 0, mode_rand = 0, clr_on_done = 0, prev_stall = 0;
  int          m_cnt = 0;
  logic [31:0] prev_addr, prev_data;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic drive_fifo();
    fifo_empty = fifo_q.size() == 0;
    fifo_rdata = fifo_empty ? 32'h0 : fifo_q[0];
  endtask
  task automatic fifo_push(input logic [31:0] w);
    fifo_q.push_back(w);
    drive_fifo();
  endtask
  task automatic exp_pkt(input logic [31:0] hdr, input logic [31:0] d[PS-1]);
    for (int i = 0; i < PS - 1; i++)
      exp_q.push_back('{addr: (hdr & 32'hFFFF_FFFC) + 32'(4 * i), data: d[i], last: i == PS - 2});
  endtask
  task automatic push_pkt(input logic [31:0] hdr, input logic [31:0] d[PS-1]);
    exp_pkt(hdr, d);
    fifo_push(hdr);
    for (int i = 0; i < PS - 1; i++) fifo_push(d[i]);
  endtask
  task automatic tick();
    logic pop, acc, done_now, clr;
    logic [31:0] a_addr, a_data;
    wr_t e;
    @(negedge clk);
    smp++;
    chk("irq", irq, m_irq);
    if (fifo_rdreq) chk("rdreq_when_empty", fifo_empty, 0);
    if (avm_write) chk("byteenable", avm_byteenable, 4'hF);
    if (prev_stall) begin
      chk("stall_write", avm_write, 1);
      chk("stall_addr", avm_address, prev_addr);
      chk("stall_data", avm_writedata, prev_data);
    end
    prev_stall = avm_write && avm_waitrequest;
    prev_addr = avm_address;
    prev_data = avm_writedata;
    if (avm_write && first_wr_smp < 0) first_wr_smp = smp;
    pop = fifo_rdreq;
    acc = avm_write && !avm_waitrequest;
    a_addr = avm_address;
    a_data = avm_writedata;
    done_now = done_pending;
    clr = irq_clear;
    @(posedge clk);
    #1;
    if (pop && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      n_pop++;
    end
    done_pending = 0;
    if (acc) begin
      n_acc++;
      if (exp_q.size() == 0) chk("unexpected_write", a_addr, 32'hDEAD_BEEF);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", a_addr, e.addr);
        chk("wr_data", a_data, e.data);
        done_pending = e.last;
      end
    end
    m_irq = done_now | (m_irq & ~clr);
    if (done_now) m_cnt++;
    drive_fifo();
    if (mode_rand) begin
      avm_waitrequest = $urandom_range(0, 2) == 0;
      irq_clear = $urandom_range(0, 7) == 0;
    end
    if (clr_on_done) irq_clear = done_pending;
  endtask
  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 300; i++) begin
      if (!busy && fifo_q.size() == 0 && exp_q.size() == 0 && !done_pending) break;
      tick();
    end
    chk({tag, "_timeout"}, i < 300, 1);
    chk({tag, "_busy"}, busy, 0);
`ifdef FIFO_PKT_MOVER_PKT_COUNT_EN
    chk({tag, "_pkt_count"}, pkt_count, 16'(m_cnt));
`endif
  endtask
  task automatic wait_acc(input int target);
    int i;
    for (i = 0; i < 50 && n_acc < target; i++) tick();
    chk("acc_timeout", i < 50, 1);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_rdreq"}, fifo_rdreq, 0);
    chk({tag, "_write"}, avm_write, 0);
    chk({tag, "_addr"}, avm_address, 0);
    chk({tag, "_data"}, avm_writedata, 0);
    chk({tag, "_be"}, avm_byteenable, 0);
    chk({tag, "_irq"}, irq, 0);
    chk({tag, "_busy"}, busy, 0);
`ifdef FIFO_PKT_MOVER_PKT_COUNT_EN
    chk({tag, "_pkt_count"}, pkt_count, 0);
`endif
  endtask
  initial begin
    logic [31:0] d[PS-1];
    int s0, base;
    #3 chk_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    d = '{32'd1, 32'd2, 32'd3};
    s0 = smp;
    first_wr_smp = -1;
    push_pkt(32'h0010_0000, d);
    wait_idle("pkt1");
    chk("first_write_latency", first_wr_smp - s0, 3);
    chk("pkt1_irq", irq, 1);
    d = '{32'd4, 32'd5, 32'd6};
    push_pkt(32'h0010_000C, d);
    wait_idle("pkt2");
    chk("pkt2_irq_held", irq, 1);
`ifdef FIFO_PKT_MOVER_PKT_COUNT_EN
    chk("pkt2_count", pkt_count, 2);
`endif
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    tick();
    chk("irq_cleared", irq, 0);
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    tick();
    chk("clear_while_low", irq, 0);
    d = '{32'd11, 32'd12, 32'd13};
    base = n_acc;
    push_pkt(32'h0010_0100, d);
    wait_acc(base + 1);
    avm_waitrequest = 1'b1;
    tick();
    s0 = n_pop;
    base = n_acc;
    repeat (5) tick();
    chk("stall_pops", n_pop - s0, 0);
    chk("stall_accepts", n_acc - base, 0);
    chk("stall_write_held", avm_write, 1);
    avm_waitrequest = 1'b0;
    tick();
    chk("stall_one_accept", n_acc - base, 1);
    wait_idle("stall");
    d = '{32'hA, 32'hB, 32'hC};
    exp_pkt(32'h0010_0003, d);
    fifo_push(32'h0010_0003);
    repeat (10) tick();
    chk("empty_wait_write", avm_write, 0);
    chk("empty_wait_busy", busy, 1);
    for (int i = 0; i < PS - 1; i++) fifo_push(d[i]);
    wait_idle("empty");
    d = '{32'hA, 32'hB, 32'hC};
    push_pkt(32'hFFFF_FFFC, d);
    wait_idle("wrap");
    mode_rand = 1;
    for (int p = 0; p < 20; p++) begin
      logic [31:0] hdr;
      hdr = $urandom;
      for (int i = 0; i < PS - 1; i++) d[i] = $urandom;
      exp_pkt(hdr, d);
      fifo_push(hdr);
      for (int i = 0; i < PS - 1; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        fifo_push(d[i]);
      end
      wait_idle("rand");
    end
    mode_rand = 0;
    avm_waitrequest = 1'b0;
    irq_clear = 1'b0;
    d = '{32'd21, 32'd22, 32'd23};
    base = n_acc;
    push_pkt(32'h0010_0040, d);
    wait_acc(base + 1);
    avm_waitrequest = 1'b1;
    tick();
    tick();
    chk("pre_reset_write", avm_write, 1);
    reset = 1'b1;
    #1 chk_zero("mid_reset");
    fifo_q.delete();
    exp_q.delete();
    drive_fifo();
    m_irq = 0;
    m_cnt = 0;
    done_pending = 0;
    prev_stall = 0;
    avm_waitrequest = 1'b0;
    @(posedge clk);
    #1 chk_zero("held_reset");
    reset = 1'b0;
    clr_on_done = 1;
    d = '{32'd7, 32'd8, 32'd9};
    push_pkt(32'h0010_0020, d);
    wait_idle("post_reset");
    clr_on_done = 0;
    irq_clear = 1'b0;
    chk("set_beats_clear", irq, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
